nibble_add_sequencer: RTL

Multi-cycle wide-operand adder controller that sequences a single external 4-bit `parallel_adder` instance. It adds two `4*NIBBLES`-bit operands plus carry-in nibble by nibble, least significant first. The carry is chained through a register between cycles. The block sits between a requester that issues `start` with operands and the shared 4-bit adder datapath, and trades latency for adder area.

---
 rtl/nibble_add_sequencer_if.sv | 37 +++
 rtl/nibble_add_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/nibble_add_sequencer_if.sv
// nibble_add_sequencer_if
//   Bundles the requester handshake and the shared 4-bit adder bus of
//   nibble_add_sequencer.
//   Requester side : start, a, b, cin  -> sequencer
//                    busy, done, sum, cout <- sequencer
//   Adder side     : add_a, add_b, add_cin -> external parallel_adder
//                    add_s, add_cout       <- external parallel_adder
//   Modports: slave  = sequencer view, master = environment view.
interface nibble_add_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_s;
    logic         add_cout;

    modport slave (
        input  start, a, b, cin, add_s, add_cout,
        output busy, done, sum, cout, add_a, add_b, add_cin
    );

    modport master (
        output start, a, b, cin, add_s, add_cout,
        input  busy, done, sum, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//   Adds two 4*NIBBLES-bit operands plus carry-in by sequencing one external
//   4-bit adder, least significant nibble first, chaining the carry through a
//   register. Latency NIBBLES cycles from accepted start to done.
//   Ports:
//     clk_i  rising-edge clock
//     rst_i  synchronous active-high reset
//     bus    nibble_add_sequencer_if.slave (requester handshake + adder bus)
module nibble_add_sequencer #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    nibble_add_sequencer_if.slave   bus
);
    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  sum_q;
    logic [W-1:0]  sum_d;
    logic          cout_q;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;

    // Current operand nibbles selected by idx_q.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                nib_a = a_q[4*n +: 4];
                nib_b = b_q[4*n +: 4];
            end
        end
    end

    // Result with the adder output merged into the current nibble slot.
    always_comb begin
        sum_d = sum_q;
        for (int unsigned n = 0; n < NIBBLES; n++) begin
            if (idx_q == IW'(n)) begin
                sum_d[4*n +: 4] = bus.add_s;
            end
        end
    end

    // Adder inputs are forced to zero outside RUN; busy_q mirrors RUN.
    assign bus.add_a   = busy_q ? nib_a : '0;
    assign bus.add_b   = busy_q ? nib_b : '0;
    assign bus.add_cin = busy_q & carry_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= bus.add_cout;
                    if (idx_q == IW'(NIBBLES - 1)) begin
                        cout_q  <= bus.add_cout;
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule
